// File: rtl/ufifo_txsched_pkg.sv
// Shared state encoding for the TX drain sequencer.
package ufifo_txsched_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE    = 2'b00;
  localparam logic [STATE_W-1:0] S_HOLDOFF = 2'b01;
  localparam logic [STATE_W-1:0] S_SEND    = 2'b10;
  localparam logic [STATE_W-1:0] S_FLUSH   = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = S_IDLE,
    ST_HOLDOFF = S_HOLDOFF,
    ST_SEND    = S_SEND,
    ST_FLUSH   = S_FLUSH
  } state_t;

endpackage

// File: rtl/ufifo_txsched_sync2ff.sv
// Two-stage synchronizer for an async input; 2-cycle latency, no backpressure.
// Reset value is a parameter so an idle "not ready" level can be chosen per pin.
module ufifo_txsched_sync2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/ufifo_txsched.sv
// Drains a ufifo into a txuart-style transmitter with burst hold-off, CTS gating and flush.
// Pop strobe is combinational; one byte is held until the transmitter accepts (stb && !busy).
module ufifo_txsched
  import ufifo_txsched_pkg::*;
#(
  parameter int BW     = 8,
  parameter int LGHOLD = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [LGHOLD-1:0] i_hold,
  input  logic              i_flush,
  input  logic              i_cts_n,
  input  logic              i_fifo_empty_n,
  input  logic              i_fifo_half_full,
  input  logic [BW-1:0]     i_fifo_data,
  output logic              o_fifo_rd,
  output logic              o_tx_stb,
  output logic [BW-1:0]     o_tx_data,
  input  logic              i_tx_busy,
  output logic              o_busy,
  output logic [1:0]        o_state,
  output logic              o_flushed
);

  state_t            state, state_nxt;
  logic              hold_v;
  logic [BW-1:0]     hold_d;
  logic [LGHOLD-1:0] hold_cnt;
  logic              cts_sync;
  logic              cts_ok;
  logic              accept;
  logic              send_pop;
  logic              load_cnt;

  ufifo_txsched_sync2ff #(.RST_VAL(1'b1)) u_cts_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_cts_n),
    .o_q   (cts_sync)
  );

  assign cts_ok    = ~cts_sync;
  assign o_tx_stb  = (state == ST_SEND) && hold_v && cts_ok;
  assign accept    = o_tx_stb && !i_tx_busy;
  // Refill the holding register only when it is empty or emptying this cycle.
  assign send_pop  = (state == ST_SEND) && i_en && i_fifo_empty_n && (!hold_v || accept);
  assign o_fifo_rd = send_pop || ((state == ST_FLUSH) && i_fifo_empty_n);
  assign o_tx_data = hold_d;
  assign o_busy    = (state != ST_IDLE);
  assign o_state   = state;
  assign o_flushed = (state == ST_FLUSH) && !i_flush && !i_fifo_empty_n;

  always_comb begin
    state_nxt = state;
    load_cnt  = 1'b0;
    if (i_flush) begin
      state_nxt = ST_FLUSH;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_en && i_fifo_empty_n) begin
            if (i_fifo_half_full || (i_hold == '0)) begin
              state_nxt = ST_SEND;
            end else begin
              state_nxt = ST_HOLDOFF;
              load_cnt  = 1'b1;
            end
          end
        end
        ST_HOLDOFF: begin
          if (!i_en)
            state_nxt = ST_IDLE;
          else if ((hold_cnt == LGHOLD'(1)) || i_fifo_half_full)
            state_nxt = ST_SEND;
        end
        ST_SEND: begin
          if (!hold_v && (!i_fifo_empty_n || !i_en))
            state_nxt = ST_IDLE;
        end
        ST_FLUSH: begin
          if (!i_fifo_empty_n)
            state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      hold_v   <= 1'b0;
      hold_d   <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;

      if (load_cnt)
        hold_cnt <= i_hold;
      else if ((state == ST_HOLDOFF) && (hold_cnt != '0))
        hold_cnt <= hold_cnt - LGHOLD'(1);

      if (send_pop)
        hold_d <= i_fifo_data;

      // Flush discards the held byte, even one popped in the same cycle.
      if (i_flush)
        hold_v <= 1'b0;
      else if (send_pop)
        hold_v <= 1'b1;
      else if (accept)
        hold_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ufifo_txsched.sv
// Directed bench for ufifo_txsched with a behavioural FIFO feeding its read side.
module tb_ufifo_txsched;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_en = 1'b0;
  logic [7:0] i_hold = 8'd0;
  logic       i_flush = 1'b0;
  logic       i_cts_n = 1'b0;
  logic       i_fifo_empty_n;
  logic       i_fifo_half_full = 1'b0;
  logic [7:0] i_fifo_data;
  logic       o_fifo_rd;
  logic       o_tx_stb;
  logic [7:0] o_tx_data;
  logic       i_tx_busy = 1'b0;
  logic       o_busy;
  logic [1:0] o_state;
  logic       o_flushed;

  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;
  int acc_cnt = 0;
  int flush_cnt = 0;
  int pop_base, acc_base, flush_base;

  logic [7:0] mem [0:63];
  logic [5:0] wp = 6'd0;
  logic [5:0] rp = 6'd0;

  assign i_fifo_empty_n = (wp != rp);
  assign i_fifo_data    = mem[rp];

  always #5 i_clk = ~i_clk;

  ufifo_txsched #(.BW(8), .LGHOLD(8)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_en             (i_en),
    .i_hold           (i_hold),
    .i_flush          (i_flush),
    .i_cts_n          (i_cts_n),
    .i_fifo_empty_n   (i_fifo_empty_n),
    .i_fifo_half_full (i_fifo_half_full),
    .i_fifo_data      (i_fifo_data),
    .o_fifo_rd        (o_fifo_rd),
    .o_tx_stb         (o_tx_stb),
    .o_tx_data        (o_tx_data),
    .i_tx_busy        (i_tx_busy),
    .o_busy           (o_busy),
    .o_state          (o_state),
    .o_flushed        (o_flushed)
  );

  always @(posedge i_clk)
    if (o_fifo_rd && (wp != rp)) rp <= rp + 6'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Mid-cycle monitor: event counts plus the never-pop-when-empty rule.
  always @(negedge i_clk) begin
    if (o_fifo_rd) pop_cnt++;
    if (o_tx_stb && !i_tx_busy) acc_cnt++;
    if (o_flushed) flush_cnt++;
    check("rd_while_empty", {31'd0, o_fifo_rd & ~i_fifo_empty_n}, 32'd0);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp] = d;
    wp = wp + 6'd1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_rd", o_fifo_rd, 0);
    check("rst_stb", o_tx_stb, 0);
    check("rst_busy", o_busy, 0);
    check("rst_state", o_state, 0);
    check("rst_flushed", o_flushed, 0);
    check("rst_data", o_tx_data, 0);
    i_rst = 1'b0;
    tick(); tick(); tick();

    // Back-to-back drain, no hold-off
    acc_base = acc_cnt;
    push(8'h41); push(8'h42); push(8'h43);
    i_en = 1'b1;
    settle();
    check("t1_c0_rd", o_fifo_rd, 0);
    check("t1_c0_state", o_state, 0);
    tick();
    check("t1_c1_state", o_state, 2);
    check("t1_c1_rd", o_fifo_rd, 1);
    check("t1_c1_stb", o_tx_stb, 0);
    tick();
    check("t1_c2_stb", o_tx_stb, 1);
    check("t1_c2_data", o_tx_data, 8'h41);
    check("t1_c2_rd", o_fifo_rd, 1);
    tick();
    check("t1_c3_data", o_tx_data, 8'h42);
    check("t1_c3_rd", o_fifo_rd, 1);
    tick();
    check("t1_c4_stb", o_tx_stb, 1);
    check("t1_c4_data", o_tx_data, 8'h43);
    check("t1_c4_rd", o_fifo_rd, 0);
    tick();
    check("t1_c5_stb", o_tx_stb, 0);
    check("t1_c5_state", o_state, 2);
    tick();
    check("t1_idle", o_state, 0);
    check("t1_busy", o_busy, 0);
    check("t1_accepts", acc_cnt - acc_base, 3);

    // Hold-off of 5 cycles
    i_hold = 8'd5;
    push(8'h55);
    settle();
    check("t2_c0_state", o_state, 0);
    tick();
    check("t2_entry_state", o_state, 1);
    check("t2_entry_rd", o_fifo_rd, 0);
    for (int k = 1; k < 5; k++) begin
      tick();
      check("t2_wait_state", o_state, 1);
      check("t2_wait_rd", o_fifo_rd, 0);
    end
    tick();
    check("t2_pop_state", o_state, 2);
    check("t2_pop_rd", o_fifo_rd, 1);
    tick();
    check("t2_stb", o_tx_stb, 1);
    check("t2_data", o_tx_data, 8'h55);
    tick(); tick();
    check("t2_idle", o_state, 0);

    // Hold-off cut short by half-full at cycle 2
    push(8'h56);
    settle();
    tick();
    check("t2b_c0_state", o_state, 1);
    tick();
    check("t2b_c1_state", o_state, 1);
    tick();
    i_fifo_half_full = 1'b1;
    settle();
    check("t2b_c2_state", o_state, 1);
    check("t2b_c2_rd", o_fifo_rd, 0);
    tick();
    i_fifo_half_full = 1'b0;
    settle();
    check("t2b_c3_state", o_state, 2);
    check("t2b_c3_rd", o_fifo_rd, 1);
    tick();
    check("t2b_data", o_tx_data, 8'h56);
    check("t2b_stb", o_tx_stb, 1);
    tick(); tick();
    check("t2b_idle", o_state, 0);

    // Transmitter busy 10 cycles per byte
    i_hold = 8'd0;
    i_tx_busy = 1'b1;
    acc_base = acc_cnt;
    pop_base = pop_cnt;
    for (int b = 0; b < 4; b++) push(8'h60 + 8'(b));
    settle();
    tick();
    check("t3_first_pop", o_fifo_rd, 1);
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 10; k++) begin
        check("t3_busy_stb", o_tx_stb, 1);
        check("t3_busy_data", o_tx_data, 8'h60 + 8'(b));
        check("t3_busy_rd", o_fifo_rd, 0);
        tick();
      end
      i_tx_busy = 1'b0;
      settle();
      check("t3_acc_data", o_tx_data, 8'h60 + 8'(b));
      check("t3_acc_rd", o_fifo_rd, (b < 3) ? 1 : 0);
      tick();
      i_tx_busy = 1'b1;
      settle();
    end
    check("t3_tail_stb", o_tx_stb, 0);
    tick();
    check("t3_idle", o_state, 0);
    check("t3_accepts", acc_cnt - acc_base, 4);
    check("t3_pops", pop_cnt - pop_base, 4);

    // CTS deasserted mid-burst
    i_tx_busy = 1'b0;
    acc_base = acc_cnt;
    for (int b = 0; b < 5; b++) push(8'h10 + 8'(b));
    settle();
    tick();
    check("t4_c1_rd", o_fifo_rd, 1);
    tick();
    check("t4_c2_data", o_tx_data, 8'h10);
    check("t4_c2_stb", o_tx_stb, 1);
    i_cts_n = 1'b1;
    tick();
    check("t4_c3_data", o_tx_data, 8'h11);
    check("t4_c3_stb", o_tx_stb, 1);
    check("t4_c3_rd", o_fifo_rd, 1);
    for (int k = 4; k <= 8; k++) begin
      tick();
      check("t4_cts_stb", o_tx_stb, 0);
      check("t4_cts_data", o_tx_data, 8'h12);
      check("t4_cts_rd", o_fifo_rd, 0);
      check("t4_cts_state", o_state, 2);
    end
    i_cts_n = 1'b0;
    tick();
    check("t4_c9_stb", o_tx_stb, 0);
    tick();
    check("t4_c10_stb", o_tx_stb, 1);
    check("t4_c10_data", o_tx_data, 8'h12);
    check("t4_c10_rd", o_fifo_rd, 1);
    tick();
    check("t4_c11_data", o_tx_data, 8'h13);
    tick();
    check("t4_c12_data", o_tx_data, 8'h14);
    check("t4_c12_rd", o_fifo_rd, 0);
    tick();
    check("t4_c13_stb", o_tx_stb, 0);
    tick();
    check("t4_idle", o_state, 0);
    check("t4_accepts", acc_cnt - acc_base, 5);

    // Flush with six queued and one held
    i_tx_busy = 1'b1;
    for (int b = 0; b < 7; b++) push(8'h70 + 8'(b));
    settle();
    tick();
    check("t5_c1_rd", o_fifo_rd, 1);
    tick();
    check("t5_c2_stb", o_tx_stb, 1);
    check("t5_c2_data", o_tx_data, 8'h70);
    acc_base = acc_cnt;
    pop_base = pop_cnt;
    flush_base = flush_cnt;
    i_flush = 1'b1;
    settle();
    check("t5_c2_rd", o_fifo_rd, 0);
    tick();
    i_flush = 1'b0;
    i_tx_busy = 1'b0;
    settle();
    for (int k = 0; k < 6; k++) begin
      check("t5_fl_state", o_state, 3);
      check("t5_fl_rd", o_fifo_rd, 1);
      check("t5_fl_stb", o_tx_stb, 0);
      check("t5_fl_pulse", o_flushed, 0);
      tick();
    end
    check("t5_done_pulse", o_flushed, 1);
    check("t5_done_rd", o_fifo_rd, 0);
    tick();
    check("t5_idle", o_state, 0);
    check("t5_pulse_low", o_flushed, 0);
    check("t5_empty", i_fifo_empty_n, 0);
    check("t5_pops", pop_cnt - pop_base, 6);
    check("t5_no_accepts", acc_cnt - acc_base, 0);
    check("t5_pulses", flush_cnt - flush_base, 1);

    // Reset while a byte is held in SEND
    i_tx_busy = 1'b1;
    push(8'h80); push(8'h81);
    settle();
    tick();
    check("t6_c1_rd", o_fifo_rd, 1);
    tick();
    check("t6_held_stb", o_tx_stb, 1);
    check("t6_held_data", o_tx_data, 8'h80);
    i_rst = 1'b1;
    tick();
    check("t6_rst_rd", o_fifo_rd, 0);
    check("t6_rst_stb", o_tx_stb, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_state", o_state, 0);
    check("t6_rst_flushed", o_flushed, 0);
    check("t6_rst_data", o_tx_data, 0);
    i_rst = 1'b0;
    i_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ufifo_txsched.md
Name: ufifo_txsched

Overview:
Drain sequencer between a ufifo instance (read side) and the UART transmitter (txuart-style stb/busy handshake). It coalesces bursts with a programmable hold-off, honours hardware CTS flow control, and supports a flush that discards queued bytes. It sits in wbuart between the TX FIFO and the serializer, replacing ad-hoc pop glue.

Parameters:
BW, 8, data byte width (matches FIFO BW)
LGHOLD, 8, width of hold-off counter and i_hold

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_en  in  1  enable draining; low = finish held byte, then stop
i_hold  in  LGHOLD  hold-off cycles before the first pop of a burst (0 = none)
i_flush  in  1  level request: discard FIFO contents and held byte
i_cts_n  in  1  async active-low clear-to-send from pin
i_fifo_empty_n  in  1  FIFO has data; i_fifo_data valid
i_fifo_half_full  in  1  FIFO half-full flag
i_fifo_data  in  BW  FIFO head entry
o_fifo_rd  out  1  single-cycle pop strobe (combinational)
o_tx_stb  out  1  byte offered to transmitter
o_tx_data  out  BW  byte offered
i_tx_busy  in  1  transmitter cannot accept
o_busy  out  1  state != IDLE
o_state  out  2  current state encoding
o_flushed  out  1  one-cycle pulse: flush complete

Behaviour:
- Reset (i_rst synchronous, active-high, clock i_clk): state=IDLE, hold_v=0, hold counter=0, CTS sync regs=1 (not clear); hence o_fifo_rd=0, o_tx_stb=0, o_busy=0, o_flushed=0, o_tx_data=0.
- FIFO contract: i_fifo_data valid whenever i_fifo_empty_n=1; after a pop the next entry and updated empty_n are valid the following clock; back-to-back pops legal. o_fifo_rd is never high while i_fifo_empty_n=0.
- Holding register hold_v/hold_d; o_tx_data=hold_d. Pop loads hold_d<=i_fifo_data, hold_v<=1.
- cts_ok = ~cts_sync after 2-FF synchronizer (2-cycle pin-to-effect latency).
- o_tx_stb = (state==SEND) && hold_v && cts_ok. accept = o_tx_stb && !i_tx_busy; accept clears hold_v unless a pop reloads it the same cycle.
- o_fifo_rd = (SEND && i_en && i_fifo_empty_n && (!hold_v || accept)) || (FLUSH && i_fifo_empty_n).
- States (2'b00 IDLE, 01 HOLDOFF, 10 SEND, 11 FLUSH):
  IDLE: if i_en && i_fifo_empty_n: half_full or i_hold==0 -> SEND; else load counter=i_hold -> HOLDOFF.
  HOLDOFF: counter decrements each cycle; -> SEND when counter==1 or i_fifo_half_full. i_hold=N gives first pop exactly N cycles after leaving IDLE. i_en low -> IDLE.
  SEND: pop/offer per rules above; -> IDLE when !hold_v && !i_fifo_empty_n, or when !i_en && !hold_v (no new pops while !i_en).
- FLUSH: i_flush high in any state -> FLUSH next cycle (priority below reset only). Entering FLUSH clears hold_v; o_tx_stb=0 in FLUSH. An accept in the same cycle i_flush is sampled counts as transmitted. Pops every cycle while empty_n; when !i_fifo_empty_n and i_flush low: o_flushed=1 for one cycle, -> IDLE. i_flush held high keeps FLUSH (writes during flush are discarded).
- CTS deassert mid-burst: held byte retained, o_tx_stb drops, no pops; resumes on reassert with no loss/duplication. Byte already accepted by transmitter unaffected.
- Counter arithmetic unsigned LGHOLD bits, no wrap (stops at transition).

Decomposition:
- Shared package: state encoding localparams (IDLE/HOLDOFF/SEND/FLUSH), 2-bit state width.
- One sub-module: sync2ff (2-stage synchronizer, reset value parameter) for i_cts_n; reused for RX-side async inputs.

Test Plan:
- i_hold=0, CTS clear, FIFO preloaded 0x41,0x42,0x43, i_tx_busy=0 -> pops on 3 consecutive cycles, o_tx_stb accepts 0x41,0x42,0x43 in order, IDLE 1 cycle after last accept.
- i_hold=5, one byte 0x55 written -> first o_fifo_rd exactly 5 cycles after HOLDOFF entry; second run with half_full asserted at cycle 2 -> SEND at cycle 3.
- i_tx_busy high 10 cycles per byte, 4 bytes -> o_tx_stb/o_tx_data stable while busy, exactly 4 accepts, pop only at accept.
- i_cts_n high after 2nd byte of 0x10..0x14 -> o_tx_stb low from 2 cycles later, 0x12 held; release -> 0x12,0x13,0x14 sent, none dropped or duplicated.
- i_flush 1-cycle pulse with 6 bytes queued and one held -> no further accepts, 6 pops, single o_flushed pulse, state IDLE, FIFO empty.
- i_rst asserted mid-SEND with hold_v=1 -> next cycle all outputs zero, state 00.
